truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_if.sv | 25 ++
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper, its controller and the
// 3-input circuit it exercises.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       drive_in1;
  logic       drive_in2;
  logic       drive_in3;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] measured;
  logic [7:0] mismatch;

  modport master (
    output start, abort, dut_out,
    input  drive_in1, drive_in2, drive_in3, busy, done, pass, measured, mismatch
  );

  modport slave (
    input  start, abort, dut_out,
    output drive_in1, drive_in2, drive_in3, busy, done, pass, measured, mismatch
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input circuit through all eight input rows, samples its output
// after a settle delay, and compares the captured truth table against TT.
module truth_table_sweeper #(
  parameter logic [7:0] TT     = 8'h46,
  parameter int         SETTLE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] measured_q, measured_d;
  logic [7:0] mismatch_q, mismatch_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    measured_d = measured_q;
    mismatch_d = mismatch_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = DRIVE;
          row_d      = 3'd0;
          cnt_d      = SETTLE_M1;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          measured_d = 8'h00;
          mismatch_d = 8'h00;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        // Abort wins over the sample; row i lands in bit 7-i (== ~i).
        if (bus.abort) begin
          state_d = IDLE;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end else begin
          measured_d[~row_q] = bus.dut_out;
          if (row_q == 3'd7) begin
            state_d = DONE;
            row_d   = 3'd0;
            busy_d  = 1'b0;
          end else begin
            state_d = DRIVE;
            row_d   = row_q + 3'd1;
            cnt_d   = SETTLE_M1;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        mismatch_d = measured_q ^ TT;
        pass_d     = (measured_q == TT);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      cnt_q      <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      measured_q <= 8'h00;
      mismatch_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      measured_q <= measured_d;
      mismatch_q <= mismatch_d;
    end
  end

  // The row register is cleared whenever not sweeping, so it doubles as the drive.
  assign bus.drive_in1 = row_q[2];
  assign bus.drive_in2 = row_q[1];
  assign bus.drive_in3 = row_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.measured  = measured_q;
  assign bus.mismatch  = mismatch_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (settle 4 and settle 1) driving modelled circuits.
module tb_truth_table_sweeper;
  localparam int         S0 = 4;
  localparam int         S1 = 1;
  localparam logic [7:0] TT = 8'h46;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sel = 1'b0;
  int         mode = 0;
  logic [7:0] lut = 8'h00;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  typedef struct {
    int         inst;
    logic [7:0] meas;
    logic [7:0] mism;
    logic       pass;
    int         done_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] trace[$];

  truth_table_sweeper_if bus0();
  truth_table_sweeper_if bus1();

  truth_table_sweeper #(.TT(TT), .SETTLE(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  truth_table_sweeper #(.TT(TT), .SETTLE(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Circuit under test: 0 = golden gate network, 1 = in3 only, else arbitrary table.
  function automatic logic circ(int m, logic [7:0] l, logic [2:0] i);
    logic in1, in2, in3;
    in1 = i[2]; in2 = i[1]; in3 = i[0];
    if (m == 0) return ((in1 & in2) | in3) & ~(in2 & in3);
    if (m == 1) return in3;
    return l[i];
  endfunction

  function automatic logic [7:0] model_table(int m, logic [7:0] l);
    logic [7:0] t;
    for (int r = 0; r < 8; r++) t[7-r] = circ(m, l, 3'(r));
    return t;
  endfunction

  function automatic int settle_of(int g);
    return (g == 0) ? S0 : S1;
  endfunction

  logic [2:0] drv_v[2];
  logic       busy_v[2], done_v[2], pass_v[2];
  logic [7:0] meas_v[2], mism_v[2];

  assign drv_v[0]  = {bus0.drive_in1, bus0.drive_in2, bus0.drive_in3};
  assign drv_v[1]  = {bus1.drive_in1, bus1.drive_in2, bus1.drive_in3};
  assign busy_v[0] = bus0.busy;     assign busy_v[1] = bus1.busy;
  assign done_v[0] = bus0.done;     assign done_v[1] = bus1.done;
  assign pass_v[0] = bus0.pass;     assign pass_v[1] = bus1.pass;
  assign meas_v[0] = bus0.measured; assign meas_v[1] = bus1.measured;
  assign mism_v[0] = bus0.mismatch; assign mism_v[1] = bus1.mismatch;

  assign bus0.start   = start & ~sel;
  assign bus1.start   = start & sel;
  assign bus0.abort   = abort & ~sel;
  assign bus1.abort   = abort & sel;
  assign bus0.dut_out = circ(mode, lut, drv_v[0]);
  assign bus1.dut_out = circ(mode, lut, drv_v[1]);

  function automatic int outs(int g);
    return int'({drv_v[g], busy_v[g], done_v[g], pass_v[g], meas_v[g], mism_v[g]});
  endfunction

  task automatic chk(string name, int act, int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (busy_v[g] === 1'b1) trace.push_back(drv_v[g]);
        if (done_v[g] === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", int'(done_v[g]), 0);
          end else begin
            exp_t e;
            int   s;
            int   bad;
            e   = sb.pop_front();
            s   = settle_of(g);
            bad = 0;
            chk("done_inst", g, e.inst);
            chk("measured", int'(meas_v[g]), int'(e.meas));
            chk("mismatch", int'(mism_v[g]), int'(e.mism));
            chk("pass", int'(pass_v[g]), int'(e.pass));
            chk("done_cycle", cyc, e.done_cyc);
            chk("busy_cycles", trace.size(), 8 * (s + 1));
            for (int j = 0; j < trace.size(); j++)
              if (trace[j] != 3'(j / (s + 1))) bad++;
            chk("row_order", bad, 0);
            trace.delete();
          end
        end
      end
    end
  endtask

  task automatic go(int g, int m, logic [7:0] l);
    exp_t       e;
    logic [7:0] t;
    @(negedge clk);
    sel  = (g != 0);
    mode = m;
    lut  = l;
    t    = model_table(m, l);
    e.inst     = g;
    e.meas     = t;
    e.mism     = t ^ TT;
    e.pass     = (t == TT);
    e.done_cyc = cyc + 1 + 8 * (settle_of(g) + 1) + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_pending", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_row(int g, logic [2:0] r);
    int n;
    n = 0;
    while (!(busy_v[g] === 1'b1 && drv_v[g] == r) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("row_reached", int'(busy_v[g] === 1'b1 && drv_v[g] == r), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) chk("reset_outs", outs(g), 0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) chk("idle_outs", outs(g), 0);
    end

    go(0, 0, 8'h00); wait_done(100);
    go(0, 1, 8'h00); wait_done(100);
    repeat (8) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(0, 2, 8'($urandom)); wait_done(100);
    end

    // Abort during the sample cycle of row 3: row 3 must not be captured.
    go(0, 1, 8'h00);
    wait_row(0, 3'd3);
    repeat (S0) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy_v[0]), 0);
    chk("abort_drive", int'(drv_v[0]), 0);
    chk("abort_pass", int'(pass_v[0]), 0);
    chk("abort_partial", int'(meas_v[0]), int'(model_table(1, 8'h00) & 8'hE0));
    sb.delete();
    trace.delete();
    repeat (60) @(negedge clk);
    go(0, 0, 8'h00); wait_done(100);

    // Accepted start clears pass; a second start mid-sweep is ignored.
    go(0, 0, 8'h00);
    chk("start_busy", int'(busy_v[0]), 1);
    chk("start_drive", int'(drv_v[0]), 0);
    chk("start_clears_pass", int'(pass_v[0]), 0);
    wait_row(0, 3'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);

    // Reset asserted mid-sweep takes effect without a clock edge.
    go(0, 1, 8'h00);
    wait_row(0, 3'd2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(0), 0);
    sb.delete();
    trace.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    go(0, 0, 8'h00); wait_done(100);

    go(1, 0, 8'h00); wait_done(60);
    go(1, 1, 8'h00); wait_done(60);
    repeat (4) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(1, 2, 8'($urandom)); wait_done(60);
    end
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
